mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum number of WAIT cycles before an access is aborted.
REQ-002 SHALL have ports as follows; clock is clk, and reset is rst, synchronous and active-low.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- ex_valid  in  1  instruction present from EX/MEM
- ex_mem_read / ex_mem_write  in  1 each  load / store
- ex_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ex_signed  in  1  sign-extend load
- ex_addr  in  32  effective address
- ex_wdata  in  32  store data, right-justified
- ex_alu_result  in  32  non-memory result
- ex_rd  in  5  destination register
- ex_reg_write  in  1  destination write enable
- dm_req  out  1  data-memory request
- dm_we  out  1  write strobe
- dm_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- dm_be  out  4  byte enables, bit3 = bits 31:24
- dm_wdata  out  32  lane-replicated store data
- dm_ack  in  1  access complete; dm_rdata valid in this cycle
- dm_rdata  in  32  read word
- mem_stall  out  1  upstream holds ex_* stable while high
- wb_valid, wb_reg_write  out  1 each  to MEM/WB
- wb_rd  out  5  to MEM/WB
- wb_data  out  32  to MEM/WB
- mem_timeout  out  1  one-cycle abort pulse
- misalign_trap  out  1  present only with MEM_MISALIGN_TRAP_EN

Function
REQ-003 SHALL implement FSM IDLE, WAIT: IDLE->WAIT on ex_valid with read or write; WAIT->IDLE on dm_ack or on timeout.
REQ-004 Non-memory ex_valid in IDLE SHALL register wb_valid=1, wb_data=ex_alu_result, wb_rd/wb_reg_write from ex_* at the next edge (1-cycle latency).
REQ-005 mem_stall SHALL be combinational: (IDLE & ex_valid & (read|write)) | (WAIT & !dm_ack).
REQ-006 In WAIT, dm_req SHALL be 1 and dm_addr/dm_we/dm_be/dm_wdata SHALL be stable until dm_ack; outside WAIT, dm_req=0.
REQ-007 Byte lanes SHALL be big-endian: byte offset k -> dm_be bit (3-k); half at addr[1]=0 -> 4'b1100, addr[1]=1 -> 4'b0011; word -> 4'b1111.
REQ-008 Store data SHALL be replicated: byte {4{b}}, half {2{h}}, word as-is.
REQ-009 A load SHALL extract the addressed lane from dm_rdata in the dm_ack cycle, zero- or sign-extend per ex_signed, and present wb_data with wb_valid=1 at the next edge.
REQ-010 A store SHALL produce wb_valid=1 and wb_reg_write=0 at the edge after dm_ack.
REQ-011 The WAIT counter SHALL start at 0 on WAIT entry; when it reaches TIMEOUT_CYCLES-1 without dm_ack, the next edge SHALL go to IDLE with wb_valid=1, wb_reg_write=0, and mem_timeout=1 for one cycle.
REQ-012 If dm_ack coincides with the final timeout cycle, dm_ack SHALL win and mem_timeout SHALL stay 0.
REQ-013 dm_ack in IDLE SHALL be ignored.
REQ-014 With ex_valid=0 in IDLE, the next edge SHALL register wb_valid=0.
REQ-015 Read and write both asserted SHALL be treated as a write.

Reset
REQ-016 With rst=0 at an edge, state SHALL become IDLE, the counter 0, and wb_valid, wb_reg_write, wb_rd, wb_data, mem_timeout, and misalign_trap 0.
REQ-017 While in IDLE after reset, dm_req, dm_we, dm_be, dm_addr, and dm_wdata SHALL be 0.
REQ-018 Reset in WAIT SHALL abandon the access with no wb_valid; a late dm_ack SHALL be ignored per REQ-013.

Configuration
REQ-019 Macro MEM_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL issue no dm_req, not stall, and at the next edge set wb_valid=1, wb_reg_write=0, misalign_trap=1 for one cycle.
REQ-020 Macro undefined: misalign_trap SHALL not exist, word accesses SHALL ignore addr[1:0], and half accesses SHALL ignore addr[0].

Structure
REQ-021 Package mem_stage_pkg SHALL hold the size enum, the state enum, and the byte-enable/extract functions.
REQ-022 Lane steering SHALL be a combinational sub-module mem_align (be, wdata replication, load extract/extend), instantiated once.

Verification
REQ-023 ALU op, ex_alu_result=32'h0000_1234, rd=5 -> next cycle wb_valid=1, wb_data=32'h0000_1234, wb_rd=5, no dm_req.
REQ-024 Signed byte load at addr 32'h100 (offset 0, so dm_be=4'b1000, bits 31:24), dm_rdata=32'h80FF_0000, ack after 3 WAIT cycles -> mem_stall high 4 cycles, wb_data=32'hFFFF_FF80.
REQ-025 Half store at 32'h202 with ex_wdata=32'h0000_ABCD -> dm_be=4'b0011, dm_wdata=32'hABCD_ABCD, dm_addr=32'h200, wb_reg_write=0.
REQ-026 Load with no dm_ack, TIMEOUT_CYCLES=4 -> dm_req high 4 cycles, then a mem_timeout pulse and wb_valid=1 with wb_reg_write=0.
REQ-027 rst=0 during WAIT, then dm_ack=1 one cycle later -> no wb_valid and dm_req=0.
REQ-028 With MEM_MISALIGN_TRAP_EN, word load at 32'h0000_0006 -> no dm_req, misalign_trap=1 for one cycle; without the macro, dm_addr=32'h4 and dm_be=4'b1111.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and lane-steering helpers for the memory stage.
// Big-endian lanes: byte offset 0 lives in bits 31:24.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_WORD_X = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_en = 4'b1000 >> off;
      SZ_HALF: byte_en = off[1] ? 4'b0011 : 4'b1100;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input size_e size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_rep = {4{wdata[7:0]}};
      SZ_HALF: store_rep = {2{wdata[15:0]}};
      default: store_rep = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input size_e size, input logic [1:0] off,
                                               input logic [31:0] rdata, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[31:24];
      2'd1:    b = rdata[23:16];
      2'd2:    b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    h = off[1] ? rdata[15:0] : rdata[31:16];
    case (size)
      SZ_BYTE: load_extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: load_extract = {{16{sgn & h[15]}}, h};
      default: load_extract = rdata;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM, data-memory and MEM/WB signals of the memory stage.
// misalign_trap exists only when MEM_MISALIGN_TRAP_EN is defined.
interface mem_stage_if;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_signed;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [31:0] ex_alu_result;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        mem_stall;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_timeout;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  modport master (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_signed, ex_addr,
           ex_wdata, ex_alu_result, ex_rd, ex_reg_write, dm_ack, dm_rdata,
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata, mem_stall,
           wb_valid, wb_reg_write, wb_rd, wb_data, mem_timeout
`ifdef MEM_MISALIGN_TRAP_EN
    , output misalign_trap
`endif
  );

  modport slave (
    output ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_signed, ex_addr,
           ex_wdata, ex_alu_result, ex_rd, ex_reg_write, dm_ack, dm_rdata,
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata, mem_stall,
           wb_valid, wb_reg_write, wb_rd, wb_data, mem_timeout
`ifdef MEM_MISALIGN_TRAP_EN
    , input misalign_trap
`endif
  );
endinterface

// File: rtl/mem_align.sv
// Combinational lane steering: byte enables, store replication, load extract/extend.
import mem_stage_pkg::*;

module mem_align (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  size_e w_size;

  assign w_size  = size_e'(i_size);
  assign o_be    = byte_en(w_size, i_off);
  assign o_wdata = store_rep(w_size, i_wdata);
  assign o_rdata = load_extract(w_size, i_off, i_rdata, i_signed);
endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory access per load/store and writes back to MEM/WB.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses without touching memory.
//
// state   | meaning
// ST_IDLE | no access outstanding; ALU results pass through to writeback
// ST_WAIT | request held on the data bus until dm_ack or timeout
import mem_stage_pkg::*;

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.master bus
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_wb_valid, w_wb_valid;
  logic             r_wb_reg_write, w_wb_reg_write;
  logic [4:0]       r_wb_rd, w_wb_rd;
  logic [31:0]      r_wb_data, w_wb_data;
  logic             r_timeout, w_timeout;
  logic             r_dm_we;
  logic [3:0]       r_dm_be;
  logic [31:0]      r_dm_addr, r_dm_wdata;
  logic             w_dm_load;
  logic             w_stall;
  logic             w_is_mem, w_misalign, w_start;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_rep, w_load_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic             r_trap, w_trap;
`endif

  assign w_is_mem = bus.ex_valid & (bus.ex_mem_read | bus.ex_mem_write);
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(size_e'(bus.ex_size), bus.ex_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_start = w_is_mem & ~w_misalign;

  mem_align u_align (
    .i_size   (bus.ex_size),
    .i_off    (bus.ex_addr[1:0]),
    .i_signed (bus.ex_signed),
    .i_wdata  (bus.ex_wdata),
    .i_rdata  (bus.dm_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata_rep),
    .o_rdata  (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // ex_* is held by the stall contract through the whole WAIT, including the ack cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_wb_valid     = 1'b0;
    w_wb_reg_write = 1'b0;
    w_wb_rd        = r_wb_rd;
    w_wb_data      = r_wb_data;
    w_timeout      = 1'b0;
    w_dm_load      = 1'b0;
    w_stall        = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    w_trap         = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_stall     = 1'b1;
          w_dm_load   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT;
        end else if (w_is_mem) begin
          w_wb_valid = 1'b1;
          w_wb_rd    = bus.ex_rd;
          w_wb_data  = '0;
`ifdef MEM_MISALIGN_TRAP_EN
          w_trap     = 1'b1;
`endif
        end else if (bus.ex_valid) begin
          w_wb_valid     = 1'b1;
          w_wb_reg_write = bus.ex_reg_write;
          w_wb_rd        = bus.ex_rd;
          w_wb_data      = bus.ex_alu_result;
        end
      end
      ST_WAIT: begin
        if (bus.dm_ack) begin
          w_state_nxt = ST_IDLE;
          w_wb_valid  = 1'b1;
          w_wb_rd     = bus.ex_rd;
          if (!bus.ex_mem_write) begin
            w_wb_reg_write = bus.ex_reg_write;
            w_wb_data      = w_load_data;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_stall     = 1'b1;
          w_state_nxt = ST_IDLE;
          w_wb_valid  = 1'b1;
          w_wb_rd     = bus.ex_rd;
          w_wb_data   = '0;
          w_timeout   = 1'b1;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt          <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_timeout      <= 1'b0;
      r_dm_we        <= 1'b0;
      r_dm_be        <= '0;
      r_dm_addr      <= '0;
      r_dm_wdata     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_trap         <= 1'b0;
`endif
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_wb_valid     <= w_wb_valid;
      r_wb_reg_write <= w_wb_reg_write;
      r_wb_rd        <= w_wb_rd;
      r_wb_data      <= w_wb_data;
      r_timeout      <= w_timeout;
`ifdef MEM_MISALIGN_TRAP_EN
      r_trap         <= w_trap;
`endif
      if (w_dm_load) begin
        r_dm_we    <= bus.ex_mem_write;
        r_dm_be    <= w_be;
        r_dm_addr  <= {bus.ex_addr[31:2], 2'b00};
        r_dm_wdata <= w_wdata_rep;
      end
    end
  end

  assign bus.dm_req       = (r_state == ST_WAIT);
  assign bus.dm_we        = r_dm_we & (r_state == ST_WAIT);
  assign bus.dm_be        = r_dm_be;
  assign bus.dm_addr      = r_dm_addr;
  assign bus.dm_wdata     = r_dm_wdata;
  assign bus.mem_stall    = w_stall;
  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_reg_write = r_wb_reg_write;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.wb_data      = r_wb_data;
  assign bus.mem_timeout  = r_timeout;
`ifdef MEM_MISALIGN_TRAP_EN
  assign bus.misalign_trap = r_trap;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with TIMEOUT_CYCLES=4.
// Checks follow the MEM_MISALIGN_TRAP_EN setting of the build.
module tb_mem_stage;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   nstall;
  int   nreq;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid      = 1'b0;
    bus.ex_mem_read   = 1'b0;
    bus.ex_mem_write  = 1'b0;
    bus.ex_size       = 2'b00;
    bus.ex_signed     = 1'b0;
    bus.ex_addr       = '0;
    bus.ex_wdata      = '0;
    bus.ex_alu_result = '0;
    bus.ex_rd         = '0;
    bus.ex_reg_write  = 1'b0;
    bus.dm_ack        = 1'b0;
    bus.dm_rdata      = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_reg_write", bus.wb_reg_write, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_timeout", bus.mem_timeout, 0);
    chk("rst_dm_req", bus.dm_req, 0);
    chk("rst_dm_we", bus.dm_we, 0);
    chk("rst_dm_be", bus.dm_be, 0);
    chk("rst_dm_addr", bus.dm_addr, 0);
    chk("rst_dm_wdata", bus.dm_wdata, 0);
    chk("rst_stall", bus.mem_stall, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_trap", bus.misalign_trap, 0);
`endif
    rst = 1'b1;

    // ALU pass-through
    bus.ex_valid = 1'b1; bus.ex_alu_result = 32'h0000_1234; bus.ex_rd = 5'd5; bus.ex_reg_write = 1'b1;
    #1 chk("alu_stall", bus.mem_stall, 0);
    tick();
    chk("alu_wb_valid", bus.wb_valid, 1);
    chk("alu_wb_data", bus.wb_data, 32'h0000_1234);
    chk("alu_wb_rd", bus.wb_rd, 5);
    chk("alu_wb_reg_write", bus.wb_reg_write, 1);
    chk("alu_dm_req", bus.dm_req, 0);
    idle_inputs();
    tick();
    chk("bubble_wb_valid", bus.wb_valid, 0);

    // signed byte load at 0x100, ack in the 4th WAIT cycle (also the last timeout cycle)
    nstall = 0;
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_size = 2'b00; bus.ex_signed = 1'b1;
    bus.ex_addr = 32'h100; bus.ex_rd = 5'd7; bus.ex_reg_write = 1'b1; bus.dm_rdata = 32'h80FF_0000;
    #1 nstall += int'(bus.mem_stall);
    tick();
    chk("ldb_dm_req", bus.dm_req, 1);
    chk("ldb_dm_addr", bus.dm_addr, 32'h100);
    chk("ldb_dm_be", bus.dm_be, 4'b1000);
    chk("ldb_dm_we", bus.dm_we, 0);
    nstall += int'(bus.mem_stall);
    tick();
    nstall += int'(bus.mem_stall);
    tick();
    nstall += int'(bus.mem_stall);
    tick();
    bus.dm_ack = 1'b1;
    #1 nstall += int'(bus.mem_stall);
    chk("ldb_req_ack_cycle", bus.dm_req, 1);
    chk("ldb_stall_cycles", nstall, 4);
    tick();
    idle_inputs();
    chk("ldb_wb_valid", bus.wb_valid, 1);
    chk("ldb_wb_data", bus.wb_data, 32'hFFFF_FF80);
    chk("ldb_wb_rd", bus.wb_rd, 7);
    chk("ldb_wb_reg_write", bus.wb_reg_write, 1);
    chk("ldb_ack_beats_timeout", bus.mem_timeout, 0);
    chk("ldb_dm_req_after", bus.dm_req, 0);

    // half store at 0x202
    bus.ex_valid = 1'b1; bus.ex_mem_write = 1'b1; bus.ex_size = 2'b01;
    bus.ex_addr = 32'h202; bus.ex_wdata = 32'h0000_ABCD; bus.ex_rd = 5'd3; bus.ex_reg_write = 1'b1;
    tick();
    chk("sth_dm_be", bus.dm_be, 4'b0011);
    chk("sth_dm_wdata", bus.dm_wdata, 32'hABCD_ABCD);
    chk("sth_dm_addr", bus.dm_addr, 32'h200);
    chk("sth_dm_we", bus.dm_we, 1);
    bus.dm_ack = 1'b1;
    #1 chk("sth_stall_ack", bus.mem_stall, 0);
    tick();
    idle_inputs();
    chk("sth_wb_valid", bus.wb_valid, 1);
    chk("sth_wb_reg_write", bus.wb_reg_write, 0);

    // stray ack in IDLE
    bus.dm_ack = 1'b1;
    tick();
    chk("idle_ack_wb_valid", bus.wb_valid, 0);
    chk("idle_ack_dm_req", bus.dm_req, 0);
    idle_inputs();

    // unsigned half load at offset 2, immediate ack
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_size = 2'b01;
    bus.ex_addr = 32'h12; bus.ex_rd = 5'd4; bus.ex_reg_write = 1'b1; bus.dm_rdata = 32'h1234_8765;
    tick();
    chk("ldh_dm_be", bus.dm_be, 4'b0011);
    bus.dm_ack = 1'b1;
    tick();
    idle_inputs();
    chk("ldh_wb_data", bus.wb_data, 32'h0000_8765);

    // read+write together is a write: byte at offset 1
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_mem_write = 1'b1; bus.ex_size = 2'b00;
    bus.ex_addr = 32'h301; bus.ex_wdata = 32'h0000_005A; bus.ex_rd = 5'd2; bus.ex_reg_write = 1'b1;
    tick();
    chk("rw_dm_we", bus.dm_we, 1);
    chk("rw_dm_be", bus.dm_be, 4'b0100);
    chk("rw_dm_wdata", bus.dm_wdata, 32'h5A5A_5A5A);
    bus.dm_ack = 1'b1;
    tick();
    idle_inputs();
    chk("rw_wb_reg_write", bus.wb_reg_write, 0);

    // timeout: word load, never acked
    nreq = 0;
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_size = 2'b10;
    bus.ex_addr = 32'h40; bus.ex_rd = 5'd9; bus.ex_reg_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      nreq += int'(bus.dm_req);
      chk("to_no_early_pulse", bus.mem_timeout, 0);
    end
    chk("to_stall_last", bus.mem_stall, 1);
    tick();
    idle_inputs();
    chk("to_req_cycles", nreq, 4);
    chk("to_pulse", bus.mem_timeout, 1);
    chk("to_wb_valid", bus.wb_valid, 1);
    chk("to_wb_reg_write", bus.wb_reg_write, 0);
    chk("to_dm_req_after", bus.dm_req, 0);
    tick();
    chk("to_pulse_one_cycle", bus.mem_timeout, 0);

    // word load at 0x6
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_size = 2'b10;
    bus.ex_addr = 32'h6; bus.ex_rd = 5'd8; bus.ex_reg_write = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
    #1 chk("mis_stall", bus.mem_stall, 0);
    tick();
    idle_inputs();
    chk("mis_dm_req", bus.dm_req, 0);
    chk("mis_trap", bus.misalign_trap, 1);
    chk("mis_wb_valid", bus.wb_valid, 1);
    chk("mis_wb_reg_write", bus.wb_reg_write, 0);
    tick();
    chk("mis_trap_one_cycle", bus.misalign_trap, 0);
`else
    tick();
    chk("mis_dm_addr", bus.dm_addr, 32'h4);
    chk("mis_dm_be", bus.dm_be, 4'b1111);
    chk("mis_dm_req", bus.dm_req, 1);
    bus.dm_ack = 1'b1;
    tick();
    idle_inputs();
`endif

    // reset while waiting, ack arrives one cycle later
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_size = 2'b10;
    bus.ex_addr = 32'h80; bus.ex_rd = 5'd6; bus.ex_reg_write = 1'b1;
    tick();
    chk("rw_wait_dm_req", bus.dm_req, 1);
    idle_inputs();
    rst = 1'b0;
    tick();
    chk("rstw_dm_req", bus.dm_req, 0);
    chk("rstw_wb_valid", bus.wb_valid, 0);
    rst = 1'b1;
    bus.dm_ack = 1'b1;
    tick();
    chk("late_ack_wb_valid", bus.wb_valid, 0);
    chk("late_ack_dm_req", bus.dm_req, 0);
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
